// File: rtl/fetch_ctrl_if.sv
// Instruction-memory read port between fetch_ctrl and the imem.
// master: fetch_ctrl (req/addr out, ready in); slave: memory side.
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: owns pc, drives imem reads, loads/flushes IF/ID.
// Ports: clk, rst, stall, pcsrc, ex_mem_npc, imem (master), pc, if_id_*, fetch_err.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                pcsrc,
  input  logic [31:0]         ex_mem_npc,
  fetch_ctrl_if.master        imem,
  output logic [31:0]         pc,
  output logic                if_id_we,
  output logic                if_id_flush,
  output logic [31:0]         if_id_npc,
  output logic                fetch_err
);

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    WAIT,
    HOLD,
    ERR
  } state_t;

  localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

  state_t      state, state_n;
  logic [31:0] pc_n;
  logic [7:0]  wait_cnt, cnt_n;
  logic        redirect_pend, pend_n;
  logic [31:0] redirect_tgt, tgt_n;
  logic        err_n;
  logic        req;

  logic        redir;
  logic [31:0] tgt;
  logic [31:0] pc_inc;

  // A same-cycle pcsrc overrides any pending target.
  assign redir  = pcsrc | redirect_pend;
  assign tgt    = (pcsrc ? ex_mem_npc : redirect_tgt) & ~32'd3;
  assign pc_inc = pc + 32'd4;

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;
  assign if_id_npc      = pc_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      wait_cnt      <= 8'd0;
      redirect_pend <= 1'b0;
      redirect_tgt  <= 32'd0;
      fetch_err     <= 1'b0;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      wait_cnt      <= cnt_n;
      redirect_pend <= pend_n;
      redirect_tgt  <= tgt_n;
      fetch_err     <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    cnt_n       = wait_cnt;
    pend_n      = redirect_pend;
    tgt_n       = redirect_tgt;
    err_n       = fetch_err;
    req         = 1'b0;
    if_id_we    = 1'b0;
    if_id_flush = 1'b0;

    unique case (state)
      BOOT: begin
        state_n = REQ;
        if (pcsrc) pc_n = tgt;
      end

      REQ: begin
        req     = 1'b1;
        cnt_n   = 8'd0;
        state_n = WAIT;
        if (pcsrc) begin
          pend_n = 1'b1;
          tgt_n  = ex_mem_npc;
        end
      end

      WAIT: begin
        req = 1'b1;
        unique case (1'b1)
          imem.imem_ready && redir: begin
            if_id_flush = 1'b1;
            pc_n        = tgt;
            pend_n      = 1'b0;
            state_n     = REQ;
          end
          imem.imem_ready && !redir && !stall: begin
            if_id_we = 1'b1;
            pc_n     = pc_inc;
            state_n  = REQ;
          end
          imem.imem_ready && !redir && stall: begin
            // Memory keeps the word stable until the next request.
            state_n = HOLD;
          end
          !imem.imem_ready: begin
            if (pcsrc) begin
              pend_n = 1'b1;
              tgt_n  = ex_mem_npc;
            end
            if (wait_cnt >= LAST) begin
              err_n   = 1'b1;
              state_n = ERR;
            end else begin
              cnt_n = wait_cnt + 8'd1;
            end
          end
          default: ;
        endcase
      end

      HOLD: begin
        if (redir) begin
          if_id_flush = 1'b1;
          pc_n        = tgt;
          pend_n      = 1'b0;
          state_n     = REQ;
        end else if (!stall) begin
          if_id_we = 1'b1;
          pc_n     = pc_inc;
          state_n  = REQ;
        end
      end

      ERR: ;

      default: state_n = BOOT;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: per-cycle reference model plus directed vectors.
// Drives inputs at posedge+1, samples on negedge.
module tb_fetch_ctrl;

  localparam logic [31:0] RPC  = 32'h100;
  localparam int          MAXW = 4;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        pcsrc;
  logic [31:0] ex_mem_npc;
  logic [31:0] pc;
  logic        if_id_we;
  logic        if_id_flush;
  logic [31:0] if_id_npc;
  logic        fetch_err;

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .RESET_PC (RPC),
    .MAX_WAIT (MAXW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .pcsrc       (pcsrc),
    .ex_mem_npc  (ex_mem_npc),
    .imem        (bus),
    .pc          (pc),
    .if_id_we    (if_id_we),
    .if_id_flush (if_id_flush),
    .if_id_npc   (if_id_npc),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: fetch transaction view.
  // m_age counts cycles since the request was issued (0 = request cycle).
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  logic        m_pend;
  logic        m_boot;
  logic        m_held;
  logic        m_err;
  int          m_age;
  logic        e_req, e_we, e_fl, decide;
  logic [31:0] nt;

  always @(negedge clk) begin
    if (rst) begin
      m_pc   = RPC;
      m_tgt  = 32'd0;
      m_pend = 1'b0;
      m_boot = 1'b1;
      m_held = 1'b0;
      m_err  = 1'b0;
      m_age  = 0;
    end
    nt     = (pcsrc ? ex_mem_npc : m_tgt) & ~32'd3;
    e_req  = !m_err && !m_boot && !m_held;
    decide = !m_err && !m_boot &&
             (m_held || (m_age > 0 && bus.imem_ready));
    e_fl   = decide && (pcsrc || m_pend);
    e_we   = decide && !e_fl && !stall;

    chk("pc", pc, m_pc);
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("if_id_npc", if_id_npc, m_pc + 32'd4);
    chk("imem_req", {31'd0, bus.imem_req}, {31'd0, e_req});
    chk("if_id_we", {31'd0, if_id_we}, {31'd0, e_we});
    chk("if_id_flush", {31'd0, if_id_flush}, {31'd0, e_fl});
    chk("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});

    if (!rst) begin
      if (m_err) begin
      end else if (m_boot) begin
        m_boot = 1'b0;
        m_age  = 0;
        if (pcsrc) m_pc = nt;
      end else if (decide) begin
        if (e_fl) begin
          m_pc   = nt;
          m_pend = 1'b0;
          m_held = 1'b0;
          m_age  = 0;
        end else if (e_we) begin
          m_pc   = m_pc + 32'd4;
          m_held = 1'b0;
          m_age  = 0;
        end else begin
          m_held = 1'b1;
        end
      end else begin
        if (pcsrc) begin
          m_pend = 1'b1;
          m_tgt  = ex_mem_npc;
        end
        if (m_age == MAXW) m_err = 1'b1;
        else m_age++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick();
    rst            = 1'b1;
    stall          = 1'b0;
    pcsrc          = 1'b0;
    bus.imem_ready = 1'b0;
    ex_mem_npc     = 32'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    stall          = 1'b0;
    pcsrc          = 1'b0;
    bus.imem_ready = 1'b0;
    ex_mem_npc     = 32'd0;

    // Back-to-back fetch, ready on every WAIT cycle
    do_reset();
    bus.imem_ready = 1'b1;
    mid(); chk("s1_boot_pc", pc, 32'h100);
    chk("s1_boot_req", {31'd0, bus.imem_req}, 32'd0);
    tick();
    mid(); chk("s1_req", {31'd0, bus.imem_req}, 32'd1);
    chk("s1_addr", bus.imem_addr, 32'h100);
    tick();
    mid(); chk("s1_we0", {31'd0, if_id_we}, 32'd1);
    chk("s1_npc0", if_id_npc, 32'h104);
    tick();
    mid(); chk("s1_pc1", pc, 32'h104);
    chk("s1_gap", {31'd0, if_id_we}, 32'd0);
    tick();
    mid(); chk("s1_npc1", if_id_npc, 32'h108);
    tick();
    mid(); chk("s1_pc2", pc, 32'h108);
    tick();
    mid(); chk("s1_we2", {31'd0, if_id_we}, 32'd1);
    chk("s1_npc2", if_id_npc, 32'h10C);

    // Stall across a ready -> HOLD, then release
    do_reset();
    bus.imem_ready = 1'b1;
    repeat (4) tick();
    stall = 1'b1;
    mid(); chk("s2_we_wait", {31'd0, if_id_we}, 32'd0);
    tick();
    mid(); chk("s2_hold_pc", pc, 32'h104);
    chk("s2_hold_req", {31'd0, bus.imem_req}, 32'd0);
    tick();
    mid(); chk("s2_hold_we", {31'd0, if_id_we}, 32'd0);
    tick();
    stall = 1'b0;
    mid(); chk("s2_rel_we", {31'd0, if_id_we}, 32'd1);
    chk("s2_rel_npc", if_id_npc, 32'h108);
    tick();
    mid(); chk("s2_rel_pc", pc, 32'h108);

    // Redirect captured mid-WAIT, committed on ready
    do_reset();
    repeat (3) tick();
    pcsrc = 1'b1; ex_mem_npc = 32'h200;
    tick();
    pcsrc = 1'b0;
    tick();
    bus.imem_ready = 1'b1;
    mid(); chk("s3_flush", {31'd0, if_id_flush}, 32'd1);
    chk("s3_we", {31'd0, if_id_we}, 32'd0);
    tick();
    bus.imem_ready = 1'b0;
    mid(); chk("s3_pc", pc, 32'h200);
    chk("s3_addr", bus.imem_addr, 32'h200);

    // Latest redirect wins; then same-cycle pcsrc+ready
    do_reset();
    repeat (3) tick();
    pcsrc = 1'b1; ex_mem_npc = 32'h200;
    tick();
    ex_mem_npc = 32'h300;
    tick();
    pcsrc = 1'b0; bus.imem_ready = 1'b1;
    mid(); chk("s3b_flush", {31'd0, if_id_flush}, 32'd1);
    tick();
    bus.imem_ready = 1'b0;
    mid(); chk("s3b_pc", pc, 32'h300);
    tick();
    bus.imem_ready = 1'b1; pcsrc = 1'b1; ex_mem_npc = 32'h404;
    mid(); chk("s3c_flush", {31'd0, if_id_flush}, 32'd1);
    chk("s3c_we", {31'd0, if_id_we}, 32'd0);
    tick();
    pcsrc = 1'b0; bus.imem_ready = 1'b0;
    mid(); chk("s3c_pc", pc, 32'h404);

    // Redirect while in HOLD, unaligned target
    do_reset();
    bus.imem_ready = 1'b1;
    tick();
    tick();
    stall = 1'b1;
    tick();
    pcsrc = 1'b1; ex_mem_npc = 32'h203;
    mid(); chk("s4_flush", {31'd0, if_id_flush}, 32'd1);
    chk("s4_we", {31'd0, if_id_we}, 32'd0);
    chk("s4_req", {31'd0, bus.imem_req}, 32'd0);
    tick();
    pcsrc = 1'b0; stall = 1'b0; bus.imem_ready = 1'b0;
    mid(); chk("s4_pc", pc, 32'h200);
    chk("s4_req2", {31'd0, bus.imem_req}, 32'd1);

    // Memory timeout -> sticky error
    do_reset();
    repeat (5) tick();
    mid(); chk("s5_err_pre", {31'd0, fetch_err}, 32'd0);
    chk("s5_req_pre", {31'd0, bus.imem_req}, 32'd1);
    tick();
    mid(); chk("s5_err", {31'd0, fetch_err}, 32'd1);
    chk("s5_req", {31'd0, bus.imem_req}, 32'd0);
    tick();
    pcsrc = 1'b1; ex_mem_npc = 32'h500; bus.imem_ready = 1'b1;
    mid(); chk("s5_err_pc", {31'd0, fetch_err}, 32'd1);
    chk("s5_no_flush", {31'd0, if_id_flush}, 32'd0);
    tick();
    pcsrc = 1'b0;
    mid(); chk("s5_pc_kept", pc, 32'h100);
    chk("s5_err_kept", {31'd0, fetch_err}, 32'd1);
    do_reset();
    mid(); chk("s5_err_clr", {31'd0, fetch_err}, 32'd0);

    // PC wrap, then async reset mid-WAIT
    do_reset();
    bus.imem_ready = 1'b1;
    pcsrc = 1'b1; ex_mem_npc = 32'hFFFF_FFFC;
    tick();
    pcsrc = 1'b0;
    mid(); chk("s6_pc_top", pc, 32'hFFFF_FFFC);
    chk("s6_npc_wrap", if_id_npc, 32'h0);
    tick();
    mid(); chk("s6_we", {31'd0, if_id_we}, 32'd1);
    tick();
    bus.imem_ready = 1'b0;
    mid(); chk("s6_pc_wrap", pc, 32'h0);
    tick();
    mid();
    #3 rst = 1'b1;
    #1;
    chk("s6_async_pc", pc, 32'h100);
    chk("s6_async_req", {31'd0, bus.imem_req}, 32'd0);
    chk("s6_async_we", {31'd0, if_id_we}, 32'd0);
    chk("s6_async_fl", {31'd0, if_id_flush}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    mid(); chk("s6_boot_req", {31'd0, bus.imem_req}, 32'd0);
    tick();
    mid(); chk("s6_restart", bus.imem_addr, 32'h100);
    chk("s6_restart_req", {31'd0, bus.imem_req}, 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
